sdram_responder: RTL and testbench
==================================

# sdram_responder

Cycle-accurate SDRAM device model that sits on the far side of the SDRAM command bus and answers the C64 core's SDRAM controller exactly as an MT48LC16M16 subset would. It decodes CS/RAS/CAS/WE commands and tracks the init sequence, mode register and per-bank open rows. It serves single-word reads after the programmed CAS latency from an internal array and flags protocol violations in sticky error bits. It is used in simulation benches and in FPGA loopback builds without external RAM.

## Interface
- `ROW_BITS`, default 8: row address bits stored; uses sd_addr[ROW_BITS-1:0] on ACTIVE.
- `COL_BITS`, default 8: column address bits stored; uses sd_addr[COL_BITS-1:0] on READ/WRITE.
- `DATA_W`, default 16: data word width.
- `TRCD`, default 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- `clk  in  1`: sole clock; all sampling on rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `sd_addr  in  13`: multiplexed address.
- `sd_ba  in  2`: bank select.
- `sd_cs, sd_ras, sd_cas, sd_we  in  1 each`: command lines, active low.
- `dq_in  in  DATA_W`: write data, sampled with WRITE.
- `dq_out  out  DATA_W`: read data.
- `dq_oe  out  1`: high for exactly the one cycle dq_out carries read data.
- `mode_reg  out  13`: last LOAD_MODE value.
- `ready  out  1`: init sequence complete.
- `err  out  6`: sticky violation flags.
- `refresh_cnt  out  16`: AUTO_REFRESH count, wraps at 0xFFFF→0.

## Operation
- Command = {cs,ras,cas,we}. INHIBIT 1xxx, NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, BST 0110 (treated as NOP), PRECHARGE 0010, AUTO_REFRESH 0001, LOAD_MODE 0000.
- Init FSM: UNINIT → (PRECHARGE with A10=1) → PRECHARGED → (LOAD_MODE) → READY. LOAD_MODE in UNINIT is accepted but does not advance. LOAD_MODE in READY reloads mode_reg. ACTIVE/READ/WRITE/AUTO_REFRESH before READY set err[0] and are ignored.
- Per bank: IDLE or ACTIVE(row, age). age saturates at TRCD and is cleared on ACTIVE.
- ACTIVE: on an ACTIVE bank sets err[3] and reopens with the new row.
- READ/WRITE: on an IDLE bank sets err[1] and is ignored. With age < TRCD it sets err[2] but is still performed.
- READ/WRITE address: {sd_ba, open_row, sd_addr[COL_BITS-1:0]}.
- A10=1 on READ/WRITE means auto-precharge; the bank is IDLE from the next cycle.
- PRECHARGE: A10=1 idles all banks; A10=0 idles sd_ba only.
- AUTO_REFRESH increments refresh_cnt; if any bank is ACTIVE it also sets err[5].
- mode_reg checks: CL = mode_reg[6:4] must be 2 or 3, BL = [2:0] must be 000, op mode = [8:7] must be 00. Any violation sets err[4] at the LOAD_MODE; the model then operates as CL=2, BL=1.
- WRITE stores dq_in at the command edge. Write burst mode bit [9] is ignored; writes are always single.
- Memory contents are undefined after power-up and are not cleared by reset.

## Timing
- Reset values: dq_out=0, dq_oe=0, mode_reg=0, ready=0, err=0, refresh_cnt=0, all banks IDLE, init FSM UNINIT, read pipeline empty.
- Reset is asynchronous and takes effect mid-operation. In-flight read data is discarded.
- Command sampled at edge t0. For READ, dq_out/dq_oe update at edge t0+CL-1, so the controller samples them at edge t0+CL.
- Read pipeline has one slot per cycle. Back-to-back READs every cycle give back-to-back dq_oe pulses.
- A WRITE at edge t to the address of a READ issued at edge t-1 does not alter that read's data.
- A READ to an address written at edge t, issued at edge ≥ t+1, returns the new data.
- ready rises on the edge that samples the qualifying LOAD_MODE.
- err bits set on the edge that samples the offending command.

## Structure
- Package `sdram_pkg`:
  - 4-bit command encodings (shared with the controller).
  - Mode field positions and the CL/BL/op mode constants.
  - err bit indices ERR_NOT_READY=0, ERR_IDLE_BANK=1, ERR_TRCD=2, ERR_ACT_OPEN=3, ERR_MODE=4, ERR_REF_OPEN=5.
- Sub-module `sdram_responder_mem`:
  - Single-port synchronous RAM, depth 4·2^(ROW_BITS+COL_BITS), DATA_W wide.
  - Write-first disabled; registered read output forms the first latency stage.
  - CL=3 adds one stage in the top level.

## Test plan
- Init: PRECHARGE A10=1, 10 NOPs, LOAD_MODE 0x220 → ready=1, mode_reg=0x220, err=0.
- Controller-style write/read, CL=2:
  - ACTIVE row 0x12; WRITE col 0x34 with A10=1 and dq_in=0xBEEF, 2 cycles later.
  - ACTIVE again; READ col 0x34 with A10=1 at t0.
  - Required: dq_oe=1 with dq_out=0xBEEF only in the cycle after edge t0+1; bank IDLE afterwards.
- CL=3: LOAD_MODE 0x230, same READ → data one cycle later than the CL=2 case; err=0.
- Violations:
  - READ with no ACTIVE → err[1].
  - READ 1 cycle after ACTIVE → err[2], data still returned.
  - AUTO_REFRESH with a bank open → err[5] and refresh_cnt+1.
- Pre-init: ACTIVE before LOAD_MODE → err[0], bank stays IDLE. LOAD_MODE 0x001 (BL=2) → err[4].
- Mid-read reset: READ at t0, reset_n low between t0 and t0+1 → dq_oe never asserts, all outputs at reset values, memory retains 0xBEEF.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, mode-register field layout and error flag indices.
package sdram_pkg;

  // {cs, ras, cas, we}, all active low
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_BST       = 4'b0110;
  localparam logic [3:0] CMD_NOP       = 4'b0111;

  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_MSB = 2;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_MSB = 6;
  localparam int MODE_OP_LSB = 7;
  localparam int MODE_OP_MSB = 8;
  localparam int ADDR_AP_BIT = 10;

  localparam logic [2:0] MODE_BL_1   = 3'b000;
  localparam logic [2:0] MODE_CL_2   = 3'd2;
  localparam logic [2:0] MODE_CL_3   = 3'd3;
  localparam logic [1:0] MODE_OP_STD = 2'b00;

  localparam int ERR_NOT_READY = 0;
  localparam int ERR_IDLE_BANK = 1;
  localparam int ERR_TRCD      = 2;
  localparam int ERR_ACT_OPEN  = 3;
  localparam int ERR_MODE      = 4;
  localparam int ERR_REF_OPEN  = 5;

  typedef enum logic [1:0] {
    INIT_UNINIT     = 2'd0,
    INIT_PRECHARGED = 2'd1,
    INIT_READY      = 2'd2
  } init_state_e;

  function automatic logic mode_ok(input logic [12:0] m);
    return ((m[MODE_CL_MSB:MODE_CL_LSB] == MODE_CL_2) || (m[MODE_CL_MSB:MODE_CL_LSB] == MODE_CL_3)) &&
           (m[MODE_BL_MSB:MODE_BL_LSB] == MODE_BL_1) &&
           (m[MODE_OP_MSB:MODE_OP_LSB] == MODE_OP_STD);
  endfunction

  // An illegal mode falls back to CL=2, so CL=3 only when the whole word is legal
  function automatic logic mode_cl3(input logic [12:0] m);
    return mode_ok(m) && (m[MODE_CL_MSB:MODE_CL_LSB] == MODE_CL_3);
  endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// Single-port synchronous word RAM; the registered read is the first read-latency stage.
module sdram_responder_mem #(
  parameter int AW     = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Contents survive reset on purpose; read returns the stored word, never the write data
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device model: command decode, init FSM, per-bank row tracking, CL-delayed reads, sticky errors.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 8,
  parameter int DATA_W   = 16,
  parameter int TRCD     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [12:0]       sd_addr,
  input  logic [1:0]        sd_ba,
  input  logic              sd_cs,
  input  logic              sd_ras,
  input  logic              sd_cas,
  input  logic              sd_we,
  input  logic [DATA_W-1:0] dq_in,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic [12:0]       mode_reg,
  output logic              ready,
  output logic [5:0]        err,
  output logic [15:0]       refresh_cnt
);

  localparam int AW    = 2 + ROW_BITS + COL_BITS;
  localparam int AGE_W = $clog2(TRCD + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TRCD);
  localparam logic [AGE_W-1:0] AGE_OK  = AGE_W'(TRCD - 1);

  init_state_e         state_q, state_d;
  logic [3:0]          open_q, open_d;
  logic [ROW_BITS-1:0] row_q [4];
  logic [ROW_BITS-1:0] row_d [4];
  logic [AGE_W-1:0]    age_q [4];
  logic [AGE_W-1:0]    age_d [4];
  logic [12:0]         mode_q, mode_d;
  logic                cl3_q, cl3_d;
  logic [5:0]          err_q, err_d;
  logic [15:0]         refresh_q, refresh_d;
  logic                rd_v0_q, rd_v0_d, rd_cl3_q, rd_cl3_d, rd_v1_q, rd_v1_d;
  logic [DATA_W-1:0]   rd_d1_q, rd_d1_d, dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;

  logic [3:0]          cmd;
  logic                is_ready, mem_we, mem_re;
  logic [AW-1:0]       mem_addr;
  logic [DATA_W-1:0]   mem_rdata;

  assign cmd      = {sd_cs, sd_ras, sd_cas, sd_we};
  assign is_ready = (state_q == INIT_READY);
  assign mem_addr = {sd_ba, row_q[sd_ba], sd_addr[COL_BITS-1:0]};

  sdram_responder_mem #(.AW(AW), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (dq_in),
    .rdata (mem_rdata)
  );

  // Command decode, bank/init bookkeeping and the read-latency pipeline
  always_comb begin
    state_d   = state_q;
    open_d    = open_q;
    mode_d    = mode_q;
    cl3_d     = cl3_q;
    err_d     = err_q;
    refresh_d = refresh_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    for (int b = 0; b < 4; b++) begin
      row_d[b] = row_q[b];
      if (open_q[b] && (age_q[b] != AGE_MAX)) age_d[b] = age_q[b] + AGE_W'(1);
      else                                    age_d[b] = age_q[b];
    end

    case (cmd)
      CMD_ACTIVE: begin
        if (!is_ready) begin
          err_d[ERR_NOT_READY] = 1'b1;
        end else begin
          err_d[ERR_ACT_OPEN] = err_q[ERR_ACT_OPEN] | open_q[sd_ba];
          open_d[sd_ba]       = 1'b1;
          row_d[sd_ba]        = sd_addr[ROW_BITS-1:0];
          age_d[sd_ba]        = '0;
        end
      end
      CMD_READ, CMD_WRITE: begin
        if (!is_ready) begin
          err_d[ERR_NOT_READY] = 1'b1;
        end else if (!open_q[sd_ba]) begin
          err_d[ERR_IDLE_BANK] = 1'b1;
        end else begin
          // age counts edges after the ACTIVE minus one, hence the TRCD-1 threshold
          err_d[ERR_TRCD] = err_q[ERR_TRCD] | (age_q[sd_ba] < AGE_OK);
          mem_we          = (cmd == CMD_WRITE);
          mem_re          = (cmd == CMD_READ);
          open_d[sd_ba]   = ~sd_addr[ADDR_AP_BIT];
        end
      end
      CMD_PRECHARGE: begin
        if (sd_addr[ADDR_AP_BIT]) begin
          open_d  = 4'b0000;
          state_d = (state_q == INIT_UNINIT) ? INIT_PRECHARGED : state_q;
        end else begin
          open_d[sd_ba] = 1'b0;
        end
      end
      CMD_REFRESH: begin
        if (!is_ready) begin
          err_d[ERR_NOT_READY] = 1'b1;
        end else begin
          refresh_d           = refresh_q + 16'd1;
          err_d[ERR_REF_OPEN] = err_q[ERR_REF_OPEN] | (|open_q);
        end
      end
      CMD_LOAD_MODE: begin
        mode_d          = sd_addr;
        cl3_d           = mode_cl3(sd_addr);
        err_d[ERR_MODE] = err_q[ERR_MODE] | ~mode_ok(sd_addr);
        state_d         = (state_q == INIT_PRECHARGED) ? INIT_READY : state_q;
      end
      CMD_NOP, CMD_BST: begin
        state_d = state_q;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    rd_v0_d  = mem_re;
    rd_cl3_d = cl3_q;
    rd_v1_d  = rd_v0_q & rd_cl3_q;
    rd_d1_d  = mem_rdata;
    if (rd_v1_q) begin
      dq_out_d = rd_d1_q;
      dq_oe_d  = 1'b1;
    end else if (rd_v0_q && !rd_cl3_q) begin
      dq_out_d = mem_rdata;
      dq_oe_d  = 1'b1;
    end else begin
      dq_out_d = dq_out_q;
      dq_oe_d  = 1'b0;
    end
  end

  // State registers; reset empties the read pipeline but leaves memory untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT_UNINIT;
      open_q    <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        row_q[b] <= '0;
        age_q[b] <= '0;
      end
      mode_q    <= 13'd0;
      cl3_q     <= 1'b0;
      err_q     <= 6'd0;
      refresh_q <= 16'd0;
      rd_v0_q   <= 1'b0;
      rd_cl3_q  <= 1'b0;
      rd_v1_q   <= 1'b0;
      rd_d1_q   <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      open_q    <= open_d;
      row_q     <= row_d;
      age_q     <= age_d;
      mode_q    <= mode_d;
      cl3_q     <= cl3_d;
      err_q     <= err_d;
      refresh_q <= refresh_d;
      rd_v0_q   <= rd_v0_d;
      rd_cl3_q  <= rd_cl3_d;
      rd_v1_q   <= rd_v1_d;
      rd_d1_q   <= rd_d1_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign mode_reg    = mode_q;
  assign ready       = is_ready;
  assign err         = err_q;
  assign refresh_cnt = refresh_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: directed protocol scenarios plus randomized traffic vs a reference model.
module tb_sdram_responder;
  import sdram_pkg::*;

  localparam int TRCD = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [12:0] sd_addr = 13'd0;
  logic [1:0]  sd_ba = 2'd0;
  logic        sd_cs = 1'b1, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
  logic [15:0] dq_in = 16'd0;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [12:0] mode_reg;
  logic        ready;
  logic [5:0]  err;
  logic [15:0] refresh_cnt;

  sdram_responder #(.ROW_BITS(8), .COL_BITS(8), .DATA_W(16), .TRCD(TRCD)) dut (
    .clk(clk), .reset_n(reset_n), .sd_addr(sd_addr), .sd_ba(sd_ba),
    .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .mode_reg(mode_reg),
    .ready(ready), .err(err), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the device as the datasheet describes it, in terms of edge numbers
  typedef struct { int e; logic [15:0] d; bit known; } exp_t;
  exp_t        q[$];
  exp_t        mon_x;
  bit          m_open [4];
  logic [7:0]  m_row [4];
  int          m_act [4];
  int          m_init;
  logic [12:0] m_mode;
  int          m_cl;
  logic [5:0]  m_err;
  logic [15:0] m_ref;
  logic [15:0] m_mem [int];

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin m_open[b] = 1'b0; m_row[b] = 8'd0; m_act[b] = 0; end
    m_init = 0; m_mode = 13'd0; m_cl = 2; m_err = 6'd0; m_ref = 16'd0;
  endtask

  task automatic model_cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                           input logic [15:0] d, input int e);
    int  key;
    bit  ok, any;
    exp_t x;
    case (c)
      CMD_ACTIVE: begin
        if (m_init != 2) m_err[0] = 1'b1;
        else begin
          if (m_open[ba]) m_err[3] = 1'b1;
          m_open[ba] = 1'b1; m_row[ba] = a[7:0]; m_act[ba] = e;
        end
      end
      CMD_READ, CMD_WRITE: begin
        if (m_init != 2) m_err[0] = 1'b1;
        else if (!m_open[ba]) m_err[1] = 1'b1;
        else begin
          if (e - m_act[ba] < TRCD) m_err[2] = 1'b1;
          key = (int'(ba) << 16) | (int'(m_row[ba]) << 8) | int'(a[7:0]);
          if (c == CMD_WRITE) m_mem[key] = d;
          else begin
            x.e = e + m_cl - 1;
            x.known = m_mem.exists(key);
            x.d = x.known ? m_mem[key] : 16'd0;
            q.push_back(x);
          end
          if (a[10]) m_open[ba] = 1'b0;
        end
      end
      CMD_PRECHARGE: begin
        if (a[10]) begin
          for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
          if (m_init == 0) m_init = 1;
        end else m_open[ba] = 1'b0;
      end
      CMD_REFRESH: begin
        if (m_init != 2) m_err[0] = 1'b1;
        else begin
          m_ref = m_ref + 16'd1;
          any = 1'b0;
          for (int b = 0; b < 4; b++) any |= m_open[b];
          if (any) m_err[5] = 1'b1;
        end
      end
      CMD_LOAD_MODE: begin
        m_mode = a;
        ok = (a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0 && a[8:7] == 2'd0;
        if (!ok) m_err[4] = 1'b1;
        m_cl = (ok && a[6:4] == 3'd3) ? 3 : 2;
        if (m_init == 1) m_init = 2;
      end
      default: ;
    endcase
  endtask

  // One command per call, driven on the falling edge and sampled on the next rising edge
  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba = ba; sd_addr = a; dq_in = d;
    model_cmd(c, ba, a, d, edge_n + 1);
    @(posedge clk);
    #1;
    {sd_cs, sd_ras, sd_cas, sd_we} = CMD_NOP;
  endtask

  task automatic nops(input int n);
    repeat (n) cmd(CMD_NOP, 2'd0, 13'd0, 16'd0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".ready"}, 32'(ready), 32'(m_init == 2));
    chk({tag, ".mode_reg"}, 32'(mode_reg), 32'(m_mode));
    chk({tag, ".refresh_cnt"}, 32'(refresh_cnt), 32'(m_ref));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.dq_oe", 32'(dq_oe), 32'd0);
    chk("rst.dq_out", 32'(dq_out), 32'd0);
    check_status("rst");
    reset_n = 1'b1;
  endtask

  task automatic init_seq(input logic [12:0] mode);
    cmd(CMD_PRECHARGE, 2'd0, 13'h400, 16'd0);
    nops(10);
    cmd(CMD_LOAD_MODE, 2'd0, mode, 16'd0);
  endtask

  task automatic random_traffic(input int n);
    int r;
    logic [1:0] ba;
    logic [12:0] a;
    for (int i = 0; i < n; i++) begin
      r  = int'($urandom_range(0, 9));
      ba = 2'($urandom_range(0, 3));
      a  = 13'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[10] = 1'b1;
      case (r)
        0, 1:    cmd(CMD_ACTIVE, ba, 13'($urandom_range(0, 1)), 16'd0);
        2, 3, 4: cmd(CMD_WRITE, ba, a, 16'($urandom));
        5, 6, 7: cmd(CMD_READ, ba, a, 16'd0);
        8:       cmd(CMD_PRECHARGE, ba, {2'b00, 1'($urandom_range(0, 1)), 10'd0}, 16'd0);
        default: cmd(($urandom_range(0, 3) == 0) ? CMD_REFRESH : CMD_NOP, ba, 13'd0, 16'd0);
      endcase
      if (i % 16 == 15) check_status("rand");
    end
  endtask

  // Scoreboard monitor: every cycle dq_oe must match whether a read is due now
  always @(negedge clk) begin
    if (reset_n) begin
      while (q.size() > 0 && q[0].e < edge_n) mon_x = q.pop_front();
      if (q.size() > 0 && q[0].e == edge_n) begin
        mon_x = q.pop_front();
        chk("dq_oe_due", 32'(dq_oe), 32'd1);
        if (mon_x.known) chk("dq_out", 32'(dq_out), 32'(mon_x.d));
      end else begin
        chk("dq_oe_idle", 32'(dq_oe), 32'd0);
      end
    end
  end

  initial begin
    int budget;
    model_reset();
    #1;
    do_reset();

    // Commands before init completes
    cmd(CMD_ACTIVE, 2'd1, 13'h012, 16'd0);
    check_status("preinit_act");
    cmd(CMD_LOAD_MODE, 2'd0, 13'h001, 16'd0);
    check_status("preinit_bl2");
    do_reset();

    init_seq(13'h220);
    check_status("init");

    // CL=2 controller-style write then read with auto-precharge
    cmd(CMD_ACTIVE, 2'd0, 13'h012, 16'd0);
    nops(1);
    cmd(CMD_WRITE, 2'd0, 13'h434, 16'hBEEF);
    nops(1);
    cmd(CMD_ACTIVE, 2'd0, 13'h012, 16'd0);
    nops(1);
    cmd(CMD_READ, 2'd0, 13'h434, 16'd0);
    nops(4);
    check_status("cl2");

    // Same read at CL=3
    cmd(CMD_LOAD_MODE, 2'd0, 13'h230, 16'd0);
    cmd(CMD_ACTIVE, 2'd0, 13'h012, 16'd0);
    nops(1);
    cmd(CMD_READ, 2'd0, 13'h434, 16'd0);
    nops(5);
    check_status("cl3");

    // Violations: idle bank, tRCD, refresh with an open bank
    cmd(CMD_READ, 2'd0, 13'h034, 16'd0);
    check_status("rd_idle");
    cmd(CMD_ACTIVE, 2'd0, 13'h012, 16'd0);
    cmd(CMD_READ, 2'd0, 13'h034, 16'd0);
    nops(4);
    check_status("trcd");
    cmd(CMD_REFRESH, 2'd0, 13'd0, 16'd0);
    check_status("ref_open");

    // Randomized traffic at CL=2 then CL=3
    do_reset();
    init_seq(13'h220);
    random_traffic(300);
    nops(4);
    cmd(CMD_LOAD_MODE, 2'd0, 13'h230, 16'd0);
    random_traffic(300);
    nops(6);
    check_status("rand_end");

    // Reset between the READ edge and its data edge
    do_reset();
    init_seq(13'h220);
    cmd(CMD_ACTIVE, 2'd0, 13'h012, 16'd0);
    nops(1);
    cmd(CMD_READ, 2'd0, 13'h034, 16'd0);
    do_reset();
    nops(5);
    init_seq(13'h220);
    cmd(CMD_ACTIVE, 2'd0, 13'h012, 16'd0);
    nops(1);
    cmd(CMD_READ, 2'd0, 13'h434, 16'd0);
    nops(4);
    check_status("post_rst");

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
